// File: rtl/bmi_pkg.sv
// Shared encodings and default constants for the sequential BMI engine.
package bmi_pkg;

    localparam int unsigned SCALE_DEF     = 100;
    localparam int unsigned TH_NORMAL_DEF = 18;
    localparam int unsigned TH_OVER_DEF   = 25;
    localparam int unsigned TH_OBESE_DEF  = 30;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PROD_W = 24;

    typedef enum logic [1:0] {
        CAT_UNDER  = 2'd0,
        CAT_NORMAL = 2'd1,
        CAT_OVER   = 2'd2,
        CAT_OBESE  = 2'd3
    } category_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_H = 3'd1,
        MUL_W = 3'd2,
        DIV   = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/seq_mul16x8.sv
// Iterative 16x8 shift-add multiplier, one multiplier bit per cycle.
// The start edge already consumes bit 0, so a product is ready after 8 edges.
module seq_mul16x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic        done,
    output logic [23:0] product
);

    logic [23:0] mcand;
    logic [7:0]  mplier;
    logic [2:0]  cnt;
    logic        run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            run     <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            product <= b[0] ? {8'h00, a} : 24'h000000;
            mcand   <= {7'h00, a, 1'b0};
            mplier  <= {1'b0, b[7:1]};
            cnt     <= 3'd1;
            run     <= 1'b1;
            done    <= 1'b0;
        end else if (run) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= {mcand[22:0], 1'b0};
            mplier <= {1'b0, mplier[7:1]};
            cnt    <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bmi_seq_ctrl.sv
// Handshaked sequential BMI engine: height^2 and SCALE*weight on a shared
// multiplier, then a 24-step restoring divide and threshold classification.
module bmi_seq_ctrl
    import bmi_pkg::*;
#(
    parameter int unsigned SCALE     = SCALE_DEF,
    parameter int unsigned TH_NORMAL = TH_NORMAL_DEF,
    parameter int unsigned TH_OVER   = TH_OVER_DEF,
    parameter int unsigned TH_OBESE  = TH_OBESE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] weight,
    input  logic [7:0] height,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] bmi,
    output logic [1:0] category,
    output logic       err,
    output logic       busy
);

    function automatic logic [7:0] sat8(input logic [23:0] q);
        return (q > 24'd255) ? 8'hFF : q[7:0];
    endfunction

    function automatic logic [1:0] classify(input logic [7:0] b);
        if (b < 8'(TH_NORMAL))    return CAT_UNDER;
        else if (b < 8'(TH_OVER))  return CAT_NORMAL;
        else if (b < 8'(TH_OBESE)) return CAT_OVER;
        else                       return CAT_OBESE;
    endfunction

    state_e      state, state_nxt;
    logic [7:0]  weight_q;
    logic [15:0] square_q;
    logic [23:0] dvd_q;
    logic [16:0] rem_q;
    logic [4:0]  div_cnt;

    logic        accept, div_last, mul_start, mul_done;
    logic [15:0] mul_a;
    logic [7:0]  mul_b;
    logic [23:0] mul_p;

    logic [16:0] rem_shift, rem_nxt;
    logic        q_bit;
    logic [23:0] quot_nxt;
    logic [7:0]  bmi_sat;

    assign accept    = in_valid && (state == IDLE);
    assign div_last  = (state == DIV) && (div_cnt == 5'd23);
    assign mul_start = (accept && (height != 8'd0)) || ((state == MUL_H) && mul_done);
    assign mul_a     = (state == IDLE) ? {8'h00, height} : 16'(SCALE);
    assign mul_b     = (state == IDLE) ? height : weight_q;

    seq_mul16x8 u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .done    (mul_done),
        .product (mul_p)
    );

    // Remainder stays below the 16-bit divisor, so the top bit never carries in.
    assign rem_shift = 17'({rem_q, dvd_q[23]});
    assign q_bit     = rem_shift >= {1'b0, square_q};
    assign rem_nxt   = q_bit ? (rem_shift - {1'b0, square_q}) : rem_shift;
    assign quot_nxt  = {dvd_q[22:0], q_bit};
    assign bmi_sat   = sat8(quot_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = (height == 8'd0) ? DONE : MUL_H;
            MUL_H:   if (mul_done) state_nxt = MUL_W;
            MUL_W:   if (mul_done) state_nxt = DIV;
            DIV:     if (div_cnt == 5'd23) state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_q <= '0;
            square_q <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            div_cnt  <= '0;
        end else begin
            if (accept) begin
                weight_q <= weight;
            end
            if ((state == MUL_H) && mul_done) begin
                square_q <= 16'(mul_p);
            end
            if ((state == MUL_W) && mul_done) begin
                dvd_q   <= mul_p;
                rem_q   <= '0;
                div_cnt <= '0;
            end else if (state == DIV) begin
                dvd_q   <= quot_nxt;
                rem_q   <= rem_nxt;
                div_cnt <= div_cnt + 5'd1;
            end
        end
    end

    // Result registers hold their last value after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmi       <= '0;
            category  <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept && (height == 8'd0)) begin
                bmi      <= 8'hFF;
                category <= CAT_OBESE;
                err      <= 1'b1;
            end else if (div_last) begin
                bmi      <= bmi_sat;
                category <= classify(bmi_sat);
                err      <= 1'b0;
            end
            out_valid <= (state == DONE) && !(out_valid && out_ready);
        end
    end

endmodule

// File: tb/tb_bmi_seq_ctrl.sv
// Randomized self-checking bench for bmi_seq_ctrl with a behavioural
// transaction model and directed literal checks.
module tb_bmi_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] weight = '0;
    logic [7:0] height = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] bmi;
    logic [1:0] category;
    logic       err;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    bit m_idle = 1'b1;
    bit m_ov = 1'b0;
    int m_due = 0;
    int m_bmi = 0;
    int m_cat = 0;
    int m_err = 0;
    int ecount = 0;

    bmi_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weight    (weight),
        .height    (height),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bmi       (bmi),
        .category  (category),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_bmi(input int w, input int h);
        int q;
        if (h == 0) return 255;
        q = (100 * w) / (h * h);
        return (q > 255) ? 255 : q;
    endfunction

    function automatic int ref_cat(input int b);
        if (b < 18) return 0;
        if (b < 25) return 1;
        if (b < 30) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: accept, fixed latency, hold until handshake.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_idle = 1'b1;
            m_ov   = 1'b0;
        end else begin
            ecount++;
            if (m_idle) begin
                if (in_valid) begin
                    m_idle = 1'b0;
                    m_due  = ecount + ((height == 8'd0) ? 1 : 41);
                    m_bmi  = ref_bmi(int'(weight), int'(height));
                    m_cat  = ref_cat(m_bmi);
                    m_err  = (height == 8'd0) ? 1 : 0;
                end
            end else if (m_ov && out_ready) begin
                m_idle = 1'b1;
            end
            m_ov = !m_idle && (ecount >= m_due);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("in_ready", int'(in_ready), int'(m_idle));
            chk("busy", int'(busy), int'(!m_idle));
            if (m_ov) begin
                chk("model_bmi", int'(bmi), m_bmi);
                chk("model_category", int'(category), m_cat);
                chk("model_err", int'(err), m_err);
            end
        end
    end

    // Returns at the negedge following the accepting edge.
    task automatic start_op(input logic [7:0] w, input logic [7:0] h);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        weight   = w;
        height   = h;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic directed(input logic [7:0] w, input logic [7:0] h, input int lat,
                            input int eb, input int ec, input int ee);
        int n;
        start_op(w, h);
        wait_valid(n);
        chk("latency", n, lat);
        chk("bmi", int'(bmi), eb);
        chk("category", int'(category), ec);
        chk("err", int'(err), ee);
        handshake();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] w, h;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bmi", int'(bmi), 0);
        chk("rst_category", int'(category), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        directed(8'd70, 8'd17, 41, 24, 1, 0);
        directed(8'd255, 8'd1, 41, 255, 3, 0);
        directed(8'd80, 8'd0, 1, 255, 3, 1);
        directed(8'd70, 8'd17, 41, 24, 1, 0);

        // Backpressure with a competing request held during DONE.
        start_op(8'd50, 8'd20);
        wait_valid(n);
        chk("bp_latency", n, 41);
        in_valid = 1'b1;
        weight   = 8'd60;
        height   = 8'd14;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_bmi", int'(bmi), 12);
            chk("bp_category", int'(category), 0);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_in_ready", int'(in_ready), 1);
        chk("bp_idle_out_valid", int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_accepted", int'(busy), 1);
        wait_valid(n);
        chk("bp2_latency", n, 41);
        chk("bp2_bmi", int'(bmi), 30);
        chk("bp2_category", int'(category), 3);
        chk("bp2_err", int'(err), 0);
        handshake();

        // Asynchronous abort in the middle of the divide.
        start_op(8'd70, 8'd17);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_bmi", int'(bmi), 0);
        chk("abort_category", int'(category), 0);
        chk("abort_err", int'(err), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        directed(8'd70, 8'd17, 41, 24, 1, 0);

        for (int i = 0; i < 40; i++) begin
            w = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0:       h = 8'd0;
                1, 2:    h = 8'($urandom_range(1, 255));
                default: h = 8'($urandom_range(10, 24));
            endcase
            start_op(w, h);
            wait_valid(n);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                @(negedge clk);
            end
            handshake();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bmi_seq_ctrl.md
Name: bmi_seq_ctrl

Overview:
- Sequential, handshaked BMI engine for area-constrained builds.
- Computes bmi = floor(SCALE*weight / height^2) on one shared 16x8 shift-add multiplier and one 24-bit restoring divider, then classifies the result.
- Sits between the measurement front-end (producer) and the display/category consumer.
- Replaces the single-cycle combinational path with a fixed-latency FSM.

Parameters:
- SCALE, 100, constant multiplier applied to weight.
- TH_NORMAL, 18, lowest bmi classed as normal.
- TH_OVER, 25, lowest bmi classed as overweight.
- TH_OBESE, 30, lowest bmi classed as obese.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has an operand pair.
- in_ready  out  1  block can accept an operand pair.
- weight  in  8  unsigned weight.
- height  in  8  unsigned height.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- bmi  out  8  saturated quotient.
- category  out  2  0 under, 1 normal, 2 over, 3 obese.
- err  out  1  height was zero.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; bmi=0; category=0; err=0; busy=0; all internal registers cleared.
- Reset asserted mid-operation aborts immediately. The in-flight operand pair is discarded; no result is produced.
- in_ready = (state==IDLE). An input is accepted on an edge where in_valid && in_ready; weight and height are latched on that edge.
- States: IDLE, MUL_H, MUL_W, DIV, DONE.
- IDLE -> MUL_H on accept with height!=0.
- IDLE -> DONE on accept with height==0. Result: err=1, bmi=8'hFF, category=3; out_valid high one cycle after accept.
- MUL_H: 8 cycles, shift-add height*height into a 16-bit square register, one multiplier bit per cycle.
- MUL_W: 8 cycles, same multiplier computing SCALE*weight into a 24-bit dividend (zero-extended).
- DIV: 24 cycles, restoring division of dividend by the zero-extended square, one quotient bit per cycle, MSB first.
- Last DIV cycle:
  - bmi = (quotient>255) ? 255 : quotient[7:0].
  - category from the saturated bmi: <TH_NORMAL -> 0; <TH_OVER -> 1; <TH_OBESE -> 2; else 3.
  - err=0.
  - Transition to DONE.
- Latency for height!=0: out_valid rises exactly 41 clock edges after the accepting edge (8+8+24+1).
- DONE: out_valid=1.
  - bmi, category and err are held stable until the edge where out_ready=1, then -> IDLE with out_valid=0.
  - Outputs keep their last values after the handshake. A new accept cannot occur until the cycle after the handshake (no same-cycle result/accept overlap).
- busy = (state!=IDLE).
- in_valid asserted while busy is ignored; the producer must hold it until in_ready.
- Arithmetic:
  - All operations are unsigned.
  - Multiplier product width is 24 bits, so no overflow is possible (max 255*255 and 100*255).
  - Divider partial remainder is 17 bits.

Decomposition:
- Shared package bmi_pkg holds:
  - category encodings CAT_UNDER=0, CAT_NORMAL=1, CAT_OVER=2, CAT_OBESE=3;
  - state encodings;
  - default thresholds and SCALE.
- One sub-module, seq_mul16x8: iterative shift-add multiplier with start/done, reused for both products.
- The divider and classifier stay inline in the controller.

Test Plan:
- weight=70, height=17 -> square 289, dividend 7000; bmi=24, category=1, err=0; out_valid exactly 41 edges after accept.
- weight=50, height=20 -> bmi=12, category=0; weight=60, height=14 -> bmi=30, category=3 (boundary hit).
- weight=255, height=1 -> quotient 25500 saturates: bmi=255, category=3, err=0.
- height=0, weight=80 -> out_valid one edge after accept; err=1, bmi=255, category=3.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 -> IDLE, and the next pair is accepted one cycle later.
- Assert rst_n=0 during DIV (cycle 30 after accept) -> all outputs 0 and in_ready=1 immediately, without waiting for a clock edge. After release, weight=70, height=17 again yields bmi=24.
